fp_dot_accum_ctrl: RTL and testbench

- Sequencer that builds a dot product from a stream of FP32 products, using one shared single-precision adder (`adder_32bit`-style: registered result, 1-cycle latency, `i_vld`/`o_res_vld`).
- Sits between the multiplier output stream and the adder.
- Feeds running-sum/product pairs to the adder, holds the partial sum, and emits one result per LEN products.

---
 rtl/fp_dot_accum_ctrl_if.sv | 37 +++
 rtl/fp_dot_accum_ctrl.sv | 138 +++++++++++++
 tb/tb_fp_dot_accum_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_dot_accum_ctrl_if.sv
// Product-in / adder-issue / result-out bundle for fp_dot_accum_ctrl; slave = controller side.
// o_err exists only when FP_DOT_ACCUM_TIMEOUT_EN is defined.
interface fp_dot_accum_ctrl_if;
  logic        i_clr;
  logic [31:0] i_prod;
  logic        i_prod_vld;
  logic        o_prod_rdy;
  logic [31:0] o_add_a;
  logic [31:0] o_add_b;
  logic        o_add_vld;
  logic [31:0] i_add_res;
  logic        i_add_res_vld;
  logic        i_add_ovf;
  logic [31:0] o_sum;
  logic        o_sum_vld;
  logic        o_ovf;
  logic        o_busy;
`ifdef FP_DOT_ACCUM_TIMEOUT_EN
  logic        o_err;
`endif

  modport slave (
    input  i_clr, i_prod, i_prod_vld, i_add_res, i_add_res_vld, i_add_ovf,
    output o_prod_rdy, o_add_a, o_add_b, o_add_vld, o_sum, o_sum_vld, o_ovf, o_busy
`ifdef FP_DOT_ACCUM_TIMEOUT_EN
    , output o_err
`endif
  );

  modport master (
    output i_clr, i_prod, i_prod_vld, i_add_res, i_add_res_vld, i_add_ovf,
    input  o_prod_rdy, o_add_a, o_add_b, o_add_vld, o_sum, o_sum_vld, o_ovf, o_busy
`ifdef FP_DOT_ACCUM_TIMEOUT_EN
    , input o_err
`endif
  );
endinterface

// File: rtl/fp_dot_accum_ctrl.sv
// FP32 dot-product sequencer over a shared 1-cycle adder: 3 cycles/term, result at last handshake+3.
// Accepts a product only in READY (o_prod_rdy low otherwise); FP_DOT_ACCUM_TIMEOUT_EN adds a WAIT watchdog and o_err.
module fp_dot_accum_ctrl #(
  parameter int LEN   = 4,
  parameter int CNT_W = 8
`ifdef FP_DOT_ACCUM_TIMEOUT_EN
  , parameter int TO_CYC = 15
`endif
) (
  input logic              clk,
  input logic              rst_n,
  fp_dot_accum_ctrl_if.slave io_bus
);

  typedef enum logic [1:0] {READY, ISSUE, WAIT} state_t;

  state_t           r_state;
  logic [31:0]      r_acc;
  logic [31:0]      r_prod_q;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf_acc;
  logic             r_add_vld;
  logic [31:0]      r_sum;
  logic             r_sum_vld;
  logic             r_ovf;
  logic             r_busy;

  logic             w_rdy;
  logic             w_hs;
  logic             w_last;
  logic             w_ovf_new;

`ifdef FP_DOT_ACCUM_TIMEOUT_EN
  localparam int WD_W = (TO_CYC < 2) ? 1 : $clog2(TO_CYC + 1);
  logic [WD_W-1:0]  r_wd;
  logic             r_err;
`endif

  // A clear in the same cycle kills the handshake, so ready is masked by it.
  assign w_rdy     = (r_state == READY) && !io_bus.i_clr;
  assign w_hs      = io_bus.i_prod_vld && w_rdy;
  assign w_last    = (r_cnt == CNT_W'(LEN - 1));
  assign w_ovf_new = r_ovf_acc | io_bus.i_add_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= READY;
      r_acc     <= 32'h0;
      r_prod_q  <= 32'h0;
      r_cnt     <= '0;
      r_ovf_acc <= 1'b0;
      r_add_vld <= 1'b0;
      r_sum     <= 32'h0;
      r_sum_vld <= 1'b0;
      r_ovf     <= 1'b0;
      r_busy    <= 1'b0;
`ifdef FP_DOT_ACCUM_TIMEOUT_EN
      r_wd      <= '0;
      r_err     <= 1'b0;
`endif
    end else begin
      r_add_vld <= 1'b0;
      r_sum_vld <= 1'b0;
`ifdef FP_DOT_ACCUM_TIMEOUT_EN
      r_err     <= 1'b0;
`endif
      if (io_bus.i_clr) begin
        r_state   <= READY;
        r_acc     <= 32'h0;
        r_cnt     <= '0;
        r_ovf_acc <= 1'b0;
        r_busy    <= 1'b0;
      end else begin
        unique case (r_state)
          READY: begin
            if (w_hs) begin
              r_prod_q  <= io_bus.i_prod;
              r_add_vld <= 1'b1;
              r_busy    <= 1'b1;
              r_state   <= ISSUE;
            end
          end
          ISSUE: begin
            r_state <= WAIT;
`ifdef FP_DOT_ACCUM_TIMEOUT_EN
            r_wd    <= '0;
`endif
          end
          WAIT: begin
            if (io_bus.i_add_res_vld) begin
              r_state <= READY;
              if (w_last) begin
                r_sum     <= io_bus.i_add_res;
                r_sum_vld <= 1'b1;
                r_ovf     <= w_ovf_new;
                r_acc     <= 32'h0;
                r_cnt     <= '0;
                r_ovf_acc <= 1'b0;
                r_busy    <= 1'b0;
              end else begin
                r_acc     <= io_bus.i_add_res;
                r_cnt     <= r_cnt + CNT_W'(1);
                r_ovf_acc <= w_ovf_new;
              end
            end
`ifdef FP_DOT_ACCUM_TIMEOUT_EN
            // Adder never answered: drop the whole dot product and flag it.
            else if (r_wd == WD_W'(TO_CYC - 1)) begin
              r_state   <= READY;
              r_acc     <= 32'h0;
              r_cnt     <= '0;
              r_ovf_acc <= 1'b0;
              r_busy    <= 1'b0;
              r_err     <= 1'b1;
            end else begin
              r_wd <= r_wd + WD_W'(1);
            end
`endif
          end
          default: r_state <= READY;
        endcase
      end
    end
  end

  assign io_bus.o_prod_rdy = w_rdy;
  assign io_bus.o_add_a    = r_acc;
  assign io_bus.o_add_b    = r_prod_q;
  assign io_bus.o_add_vld  = r_add_vld;
  assign io_bus.o_sum      = r_sum;
  assign io_bus.o_sum_vld  = r_sum_vld;
  assign io_bus.o_ovf      = r_ovf;
  assign io_bus.o_busy     = r_busy;
`ifdef FP_DOT_ACCUM_TIMEOUT_EN
  assign io_bus.o_err      = r_err;
`endif

endmodule

// File: tb/tb_fp_dot_accum_ctrl.sv
// Bench for fp_dot_accum_ctrl: 1-cycle adder responder, running-sum reference in real arithmetic.
module tb_fp_dot_accum_ctrl;
  localparam int LEN = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fp_dot_accum_ctrl_if bus();
  fp_dot_accum_ctrl #(.LEN(LEN), .CNT_W(8)) dut (.clk(clk), .rst_n(rst_n), .io_bus(bus));

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit          ovf_q[$];
  bit          mute = 1'b0;
  int          spur_req = 0;
  int          spur_done = 0;
  logic [31:0] add_a_q[$];
  logic [31:0] add_b_q[$];
  int          add_c_q[$];
  logic [31:0] sum_q[$];
  logic        sov_q[$];
  logic        srdy_q[$];
  int          sum_c_q[$];
  logic [31:0] tp[$];
  bit          tovf[$];

  function automatic real f2r(input logic [31:0] b);
    real m;
    int  e;
    if (b[30:23] == 8'd0) return 0.0;
    m = 1.0 + real'(b[22:0]) / 8388608.0;
    e = int'(b[30:23]) - 127;
    while (e > 0) begin m = m * 2.0; e--; end
    while (e < 0) begin m = m / 2.0; e++; end
    return b[31] ? -m : m;
  endfunction

  function automatic logic [31:0] r2f(input real x);
    logic        s;
    int          e;
    real         m;
    logic [22:0] f;
    if (x == 0.0) return 32'h0;
    s = (x < 0.0);
    m = s ? -x : x;
    e = 127;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0)  begin m = m * 2.0; e--; end
    f = 23'(longint'((m - 1.0) * 8388608.0));
    return {s, 8'(e), f};
  endfunction

  // Adder responder: result visible the cycle after an issue strobe.
  initial begin
    logic        pv;
    logic [31:0] pr;
    logic        po;
    pv = 1'b0; pr = 32'h0; po = 1'b0;
    bus.i_add_res_vld = 1'b0;
    bus.i_add_res     = 32'h0;
    bus.i_add_ovf     = 1'b0;
    forever begin
      @(posedge clk); #1;
      bus.i_add_res_vld = pv;
      bus.i_add_res     = pr;
      bus.i_add_ovf     = po;
      if (!pv && spur_req != spur_done) begin
        bus.i_add_res_vld = 1'b1;
        bus.i_add_res     = 32'h4480_0000;
        bus.i_add_ovf     = 1'b1;
        spur_done         = spur_req;
      end
      pv = 1'b0;
      po = 1'b0;
      if (bus.o_add_vld === 1'b1) begin
        po = (ovf_q.size() > 0) ? ovf_q.pop_front() : 1'b0;
        pv = !mute;
        pr = r2f(f2r(bus.o_add_a) + f2r(bus.o_add_b));
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #2;
      if (bus.o_add_vld === 1'b1) begin
        add_a_q.push_back(bus.o_add_a);
        add_b_q.push_back(bus.o_add_b);
        add_c_q.push_back(cyc);
      end
      if (bus.o_sum_vld === 1'b1) begin
        sum_q.push_back(bus.o_sum);
        sov_q.push_back(bus.o_ovf);
        srdy_q.push_back(bus.o_prod_rdy);
        sum_c_q.push_back(cyc);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [31:0] p, input bit ovf, output int hs);
    bus.i_prod     = p;
    bus.i_prod_vld = 1'b1;
    hs = -1;
    for (int k = 0; k < 40; k++) begin
      if (bus.o_prod_rdy === 1'b1) begin
        hs = cyc;
        ovf_q.push_back(ovf);
        tick(1);
        break;
      end
      tick(1);
    end
    chk("handshake_seen", 32'(hs >= 0), 32'd1);
    if (hs >= 0) chk("rdy_low_after_hs", 32'(bus.o_prod_rdy), 32'd0);
  endtask

  task automatic run_dot(input string tag, input int gap, input bit spur);
    real         acc;
    logic [31:0] ea[$];
    int          hs;
    int          last_hs;
    bit          eovf;
    int          n;
    acc = 0.0; eovf = 1'b0; last_hs = 0;
    add_a_q.delete(); add_b_q.delete(); add_c_q.delete();
    for (int i = 0; i < tp.size(); i++) begin
      ea.push_back(r2f(acc));
      acc  = acc + f2r(tp[i]);
      eovf = eovf | tovf[i];
      send(tp[i], tovf[i], hs);
      last_hs = hs;
      if (spur && i == 1) begin
        bus.i_prod_vld = 1'b0;
        tick(3);
        chk({tag, " busy_mid"}, 32'(bus.o_busy), 32'd1);
        spur_req++;
        tick(3);
      end else if (gap > 0) begin
        bus.i_prod_vld = 1'b0;
        tick(gap);
      end
    end
    bus.i_prod_vld = 1'b0;
    for (int k = 0; k < 40 && sum_q.size() == 0; k++) tick(1);
    chk({tag, " n_issue"}, 32'(add_a_q.size()), 32'(tp.size()));
    n = (add_a_q.size() < tp.size()) ? add_a_q.size() : tp.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, $sformatf(" add_a[%0d]", i)}, add_a_q[i], ea[i]);
      chk({tag, $sformatf(" add_b[%0d]", i)}, add_b_q[i], tp[i]);
      if (gap == 0 && !spur && i > 0)
        chk({tag, $sformatf(" issue_gap[%0d]", i)}, 32'(add_c_q[i] - add_c_q[i-1]), 32'd3);
    end
    chk({tag, " sum_seen"}, 32'(sum_q.size()), 32'd1);
    if (sum_q.size() > 0) begin
      chk({tag, " sum"}, sum_q.pop_front(), r2f(acc));
      chk({tag, " ovf"}, 32'(sov_q.pop_front()), 32'(eovf));
      chk({tag, " rdy_at_sum"}, 32'(srdy_q.pop_front()), 32'd1);
      chk({tag, " sum_cycle"}, 32'(sum_c_q.pop_front()), 32'(last_hs + 3));
    end
    chk({tag, " busy_end"}, 32'(bus.o_busy), 32'd0);
    sum_q.delete(); sov_q.delete(); srdy_q.delete(); sum_c_q.delete();
  endtask

  task automatic load4(input logic [31:0] a, b, c, d, input bit oa, ob, oc, od);
    tp.delete(); tovf.delete();
    tp.push_back(a); tp.push_back(b); tp.push_back(c); tp.push_back(d);
    tovf.push_back(oa); tovf.push_back(ob); tovf.push_back(oc); tovf.push_back(od);
  endtask

  task automatic load_rand();
    int k;
    tp.delete(); tovf.delete();
    for (int i = 0; i < LEN; i++) begin
      k = int'($urandom_range(0, 16)) - 8;
      tp.push_back(r2f(real'(k) / 4.0));
      tovf.push_back(($urandom_range(0, 3) == 0));
    end
  endtask

  initial begin
    int hs;
    int ec;
    bus.i_clr = 1'b0;
    bus.i_prod = 32'h0;
    bus.i_prod_vld = 1'b0;
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(1);

    chk("rst add_vld", 32'(bus.o_add_vld), 32'd0);
    chk("rst add_a", bus.o_add_a, 32'h0);
    chk("rst add_b", bus.o_add_b, 32'h0);
    chk("rst sum", bus.o_sum, 32'h0);
    chk("rst sum_vld", 32'(bus.o_sum_vld), 32'd0);
    chk("rst ovf", 32'(bus.o_ovf), 32'd0);
    chk("rst busy", 32'(bus.o_busy), 32'd0);
    chk("rst prod_rdy", 32'(bus.o_prod_rdy), 32'd1);
`ifdef FP_DOT_ACCUM_TIMEOUT_EN
    chk("rst err", 32'(bus.o_err), 32'd0);
`endif

    load4(32'h3FC0_0000, 32'h4010_0000, 32'hBF40_0000, 32'h3F80_0000, 0, 0, 0, 0);
    run_dot("dir", 0, 1'b0);

    load4(32'h3FC0_0000, 32'h4010_0000, 32'hBF40_0000, 32'h3F80_0000, 0, 1, 0, 0);
    run_dot("ovf2", 0, 1'b0);
    load4(32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 0, 0, 0, 0);
    run_dot("ones", 0, 1'b0);

    // Abort two terms in, with a product offered alongside the clear.
    add_a_q.delete();
    send(32'h4000_0000, 1'b1, hs);
    send(32'h4040_0000, 1'b1, hs);
    tick(1);
    bus.i_clr = 1'b1;
    #1 chk("clr rdy_in_wait", 32'(bus.o_prod_rdy), 32'd0);
    tick(1);
    chk("clr rdy_forced_low", 32'(bus.o_prod_rdy), 32'd0);
    tick(1);
    bus.i_clr = 1'b0;
    bus.i_prod_vld = 1'b0;
    chk("clr no_capture", 32'(bus.o_add_vld), 32'd0);
    chk("clr busy", 32'(bus.o_busy), 32'd0);
    tick(4);
    chk("clr no_sum", 32'(sum_q.size()), 32'd0);
    load4(32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 0, 0, 0, 0);
    run_dot("after_clr", 0, 1'b0);

    load_rand();
    run_dot("spur", 1, 1'b1);

    // Reset while the adder result is outstanding.
    send(32'h4100_0000, 1'b1, hs);
    bus.i_prod_vld = 1'b0;
    tick(1);
    rst_n = 1'b0;
    #1;
    chk("rstw add_vld", 32'(bus.o_add_vld), 32'd0);
    chk("rstw add_a", bus.o_add_a, 32'h0);
    chk("rstw sum", bus.o_sum, 32'h0);
    chk("rstw sum_vld", 32'(bus.o_sum_vld), 32'd0);
    chk("rstw ovf", 32'(bus.o_ovf), 32'd0);
    chk("rstw busy", 32'(bus.o_busy), 32'd0);
    tick(1);
    rst_n = 1'b1;
    tick(1);
    chk("rstw prod_rdy", 32'(bus.o_prod_rdy), 32'd1);
    ovf_q.delete();
    load_rand();
    run_dot("after_rst", 0, 1'b0);

    for (int r = 0; r < 8; r++) begin
      load_rand();
      run_dot($sformatf("rnd%0d", r), int'($urandom_range(0, 3)), 1'b0);
    end

`ifdef FP_DOT_ACCUM_TIMEOUT_EN
    mute = 1'b1;
    send(32'h3F80_0000, 1'b1, hs);
    bus.i_prod_vld = 1'b0;
    ec = -1;
    for (int k = 0; k < 40; k++) begin
      if (bus.o_err === 1'b1) begin ec = cyc; break; end
      tick(1);
    end
    chk("to err_cycle", 32'(ec), 32'(hs + 17));
    tick(1);
    chk("to err_pulse", 32'(bus.o_err), 32'd0);
    chk("to rdy", 32'(bus.o_prod_rdy), 32'd1);
    chk("to no_sum", 32'(sum_q.size()), 32'd0);
    mute = 1'b0;
    load4(32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 0, 0, 0, 0);
    run_dot("after_to", 0, 1'b0);
`else
    ec = 0;
`endif

    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
